mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_BITS, default 24, width of every address port (matches mapper bus address width).
REQ-002 Parameter TIMEOUT, default 63, max cycles to wait for mem_ack before abort; legal 1..255.
REQ-003 clk  input  1  single clock for all state.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 prg_req / chr_req  input  1 each  requester holds high until its ack.
REQ-006 prg_addr / chr_addr  input  ADDR_BITS each  request address, stable while req high.
REQ-007 prg_we / chr_we  input  1 each  1 = write, 0 = read.
REQ-008 prg_wdata / chr_wdata  input  8 each  write data.
REQ-009 prg_ack / chr_ack  output  1 each  one-cycle completion pulse.
REQ-010 rdata  output  8  read data, valid in the cycle any ack is high.
REQ-011 err  output  1  one-cycle pulse alongside an ack when the access timed out.
REQ-012 mem_req  output  1  request to memory controller.
REQ-013 mem_addr  output  ADDR_BITS; mem_we  output  1; mem_wdata  output  8  registered command.
REQ-014 mem_ack  input  1  one-cycle completion from memory; mem_rdata  input  8  valid with mem_ack.

Function
REQ-015 FSM states IDLE, ISSUE, WAIT, DONE; one access in flight at most.
REQ-016 IDLE: if any req high, latch winner's addr/we/wdata into mem_* registers and owner, go ISSUE next cycle; else stay.
REQ-017 Arbitration: a single pending requester wins; both pending -> round-robin, the requester not served last wins; after reset, chr wins first.
REQ-018 ISSUE: mem_req high for exactly one cycle, then WAIT.
REQ-019 WAIT: mem_ack high -> capture mem_rdata, go DONE; 8-bit wait counter increments each WAIT cycle; counter reaching TIMEOUT without mem_ack -> rdata = 8'hFF, err set, go DONE.
REQ-020 DONE: owner's ack high one cycle, rdata held, err high if timed out; go IDLE; minimum request-to-ack latency 4 cycles (IDLE, ISSUE, WAIT with same-cycle mem_ack, DONE).
REQ-021 mem_ack outside WAIT is ignored; a late mem_ack after timeout does not alter rdata or produce an ack.
REQ-022 Requester dropping req before its ack: access still completes on memory, ack still pulses, requester ignores it.
REQ-023 Back-to-back: requester re-asserting in the cycle after its ack is eligible in that IDLE cycle; round-robin applies.
REQ-024 mem_addr/mem_we/mem_wdata stable from ISSUE through DONE.
REQ-025 Write accesses: rdata is don't-care except on timeout (8'hFF).

Reset
REQ-026 reset asserted at any time, including mid-access, forces IDLE immediately: mem_req=0, all acks=0, err=0, rdata=8'hFF, mem_addr=0, mem_we=0, mem_wdata=0, wait counter=0, last-served=prg (chr wins first).
REQ-027 In-flight access aborted by reset produces no ack; a subsequent mem_ack is ignored.

Configuration
REQ-028 Macro MEM_ARBITER_SST_PORT_EN defined: adds sst_req, sst_addr, sst_we, sst_wdata inputs and sst_ack output (same rules), save-state port strictly lowest priority, served only when prg_req and chr_req both low in IDLE.
REQ-029 Macro undefined: sst ports absent, two-requester behaviour exactly as REQ-017.

Verification
REQ-030 prg read 0x00_8000, mem_ack one cycle after ISSUE with mem_rdata 0x5A -> prg_ack one pulse, rdata 0x5A, err 0, chr_ack 0.
REQ-031 prg_req and chr_req raised same cycle, held for three accesses each -> grant order chr, prg, chr, prg, chr, prg.
REQ-032 chr write 0x00_1400 data 0x3C, mem never acks, TIMEOUT=63 -> chr_ack with err=1, rdata 0xFF after 63 WAIT cycles; late mem_ack ignored.
REQ-033 reset pulsed during WAIT of prg read -> no prg_ack, mem_req 0, next access after reset granted to chr if both pending.
REQ-034 mem_ack pulsed while IDLE with no requests -> no ack, rdata unchanged.
REQ-035 With MEM_ARBITER_SST_PORT_EN, sst_req held while prg_req toggles every access -> sst served only in IDLE cycles with prg_req and chr_req low.

Source files
------------

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port (optionally three-port) round-robin arbiter in front of a single-access memory controller
// Optional save-state port: define MEM_ARBITER_SST_PORT_EN.
module mem_arbiter #(
    parameter int ADDR_BITS = 24,
    parameter int TIMEOUT   = 63
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 prg_req,
    input  logic [ADDR_BITS-1:0] prg_addr,
    input  logic                 prg_we,
    input  logic [7:0]           prg_wdata,
    input  logic                 chr_req,
    input  logic [ADDR_BITS-1:0] chr_addr,
    input  logic                 chr_we,
    input  logic [7:0]           chr_wdata,
`ifdef MEM_ARBITER_SST_PORT_EN
    input  logic                 sst_req,
    input  logic [ADDR_BITS-1:0] sst_addr,
    input  logic                 sst_we,
    input  logic [7:0]           sst_wdata,
    output logic                 sst_ack,
`endif
    output logic                 prg_ack,
    output logic                 chr_ack,
    output logic [7:0]           rdata,
    output logic                 err,
    output logic                 mem_req,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic                 mem_we,
    output logic [7:0]           mem_wdata,
    input  logic                 mem_ack,
    input  logic [7:0]           mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [1:0] OWN_PRG = 2'd0;
    localparam logic [1:0] OWN_CHR = 2'd1;
`ifdef MEM_ARBITER_SST_PORT_EN
    localparam logic [1:0] OWN_SST = 2'd2;
`endif
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    state_t                 r_state;
    state_t                 w_next_state;
    logic [1:0]             r_owner;
    logic                   r_last_chr;
    logic [7:0]             r_wait_cnt;
    logic                   r_timeout;
    logic [7:0]             r_rdata;
    logic [ADDR_BITS-1:0]   r_mem_addr;
    logic                   r_mem_we;
    logic [7:0]             r_mem_wdata;

    logic                   w_grant_valid;
    logic [1:0]             w_grant;
    logic [ADDR_BITS-1:0]   w_grant_addr;
    logic                   w_grant_we;
    logic [7:0]             w_grant_wdata;
    logic                   w_timeout_hit;

    assign w_timeout_hit = (r_wait_cnt == TIMEOUT_LAST);

    // Contention between prg and chr goes to whoever was not served last.
    always_comb begin
        w_grant_valid = 1'b0;
        w_grant       = OWN_PRG;
        if (prg_req && chr_req) begin
            w_grant_valid = 1'b1;
            w_grant       = r_last_chr ? OWN_PRG : OWN_CHR;
        end else if (prg_req) begin
            w_grant_valid = 1'b1;
            w_grant       = OWN_PRG;
        end else if (chr_req) begin
            w_grant_valid = 1'b1;
            w_grant       = OWN_CHR;
        end
`ifdef MEM_ARBITER_SST_PORT_EN
        else if (sst_req) begin
            w_grant_valid = 1'b1;
            w_grant       = OWN_SST;
        end
`endif
    end

    always_comb begin
        w_grant_addr  = prg_addr;
        w_grant_we    = prg_we;
        w_grant_wdata = prg_wdata;
        case (w_grant)
            OWN_CHR: begin
                w_grant_addr  = chr_addr;
                w_grant_we    = chr_we;
                w_grant_wdata = chr_wdata;
            end
`ifdef MEM_ARBITER_SST_PORT_EN
            OWN_SST: begin
                w_grant_addr  = sst_addr;
                w_grant_we    = sst_we;
                w_grant_wdata = sst_wdata;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_grant_valid) w_next_state = S_ISSUE;
            S_ISSUE: w_next_state = S_WAIT;
            S_WAIT:  if (mem_ack || w_timeout_hit) w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_owner     <= OWN_PRG;
            r_last_chr  <= 1'b0;
            r_wait_cnt  <= 8'd0;
            r_timeout   <= 1'b0;
            r_rdata     <= 8'hFF;
            r_mem_addr  <= '0;
            r_mem_we    <= 1'b0;
            r_mem_wdata <= 8'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant_valid) begin
                        r_owner     <= w_grant;
                        r_mem_addr  <= w_grant_addr;
                        r_mem_we    <= w_grant_we;
                        r_mem_wdata <= w_grant_wdata;
                        r_wait_cnt  <= 8'd0;
                        r_timeout   <= 1'b0;
                        // Save-state grants leave the prg/chr rotation untouched.
                        if (w_grant == OWN_CHR) begin
                            r_last_chr <= 1'b1;
                        end else if (w_grant == OWN_PRG) begin
                            r_last_chr <= 1'b0;
                        end
                    end
                end
                S_WAIT: begin
                    if (mem_ack) begin
                        r_rdata <= mem_rdata;
                    end else if (w_timeout_hit) begin
                        r_rdata   <= 8'hFF;
                        r_timeout <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        mem_req = (r_state == S_ISSUE);
        prg_ack = (r_state == S_DONE) && (r_owner == OWN_PRG);
        chr_ack = (r_state == S_DONE) && (r_owner == OWN_CHR);
`ifdef MEM_ARBITER_SST_PORT_EN
        sst_ack = (r_state == S_DONE) && (r_owner == OWN_SST);
`endif
        err     = (r_state == S_DONE) && r_timeout;
    end

    assign rdata     = r_rdata;
    assign mem_addr  = r_mem_addr;
    assign mem_we    = r_mem_we;
    assign mem_wdata = r_mem_wdata;

endmodule
